rc4_key_search: RTL and testbench

// Parametrised brute-force key searcher for the RC4 decrypt datapath. Sweeps a key
// sub-range [key_lo, key_hi] in steps of KEY_STEP. For each key it triggers the

---
 rtl/rc4_key_search.sv | 178 +++++++++++++++++
 tb/tb_rc4_key_search.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_key_search.sv
// Brute-force RC4 key searcher: sweeps [key_lo, key_hi] in KEY_STEP increments,
// launches the decrypt core per key and scans the decrypted bytes against a
// character set, rejecting a key on its first out-of-set byte.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for start, no search in progress
// LAUNCH    | core_start high for this cycle, byte address rewound to 0
// WAIT_CORE | decrypt core running, waiting for core_done
// ISSUE     | ram_addr presented, latency down-counter loaded
// WAIT_RAM  | counting down RAM read latency, sample byte at terminal count
// CHECK     | test sampled byte against the character set
// NEXT_KEY  | key rejected, advance key or finish with not_found
// DONE      | search finished, result flags and key held until next start
module rc4_key_search #(
    parameter int KEY_W    = 24,
    parameter int MSG_LEN  = 32,
    parameter int ADDR_W   = 5,
    parameter int RAM_LAT  = 1,
    parameter int KEY_STEP = 1,
    parameter int CHARSET  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [KEY_W-1:0]  key_lo,
    input  logic [KEY_W-1:0]  key_hi,
    output logic              core_start,
    input  logic              core_done,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_data,
    output logic [KEY_W-1:0]  key,
    output logic              busy,
    output logic              found,
    output logic              not_found,
    output logic [KEY_W-1:0]  keys_tried
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_CORE,
        S_ISSUE,
        S_WAIT_RAM,
        S_CHECK,
        S_NEXT_KEY,
        S_DONE
    } state_t;

    localparam int                LAT_W     = $clog2(RAM_LAT + 1);
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(RAM_LAT);
    localparam logic [LAT_W-1:0]  LAT_TC    = LAT_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);
    // Key arithmetic is one bit wider so the range end can never wrap to 0.
    localparam logic [KEY_W:0]    STEP_X    = (KEY_W + 1)'(KEY_STEP);

    state_t             state;
    logic [KEY_W-1:0]   hi_q;
    logic [LAT_W-1:0]   lat_cnt;
    logic [7:0]         byte_q;
    logic               byte_ok;
    logic               in_busy_state;
    logic [KEY_W:0]     key_next_x;
    logic               range_done;

    // Character-set test on the sampled byte.
    always_comb begin
        byte_ok = 1'b0;
        if (CHARSET == 0) begin
            byte_ok = ((byte_q >= 8'd97) && (byte_q <= 8'd122)) || (byte_q == 8'd32);
        end else begin
            byte_ok = (byte_q >= 8'd32) && (byte_q <= 8'd126);
        end
    end

    // Next-key candidate and range-exhausted decision, evaluated without wrap.
    always_comb begin
        key_next_x    = {1'b0, key} + STEP_X;
        range_done    = key_next_x > {1'b0, hi_q};
        in_busy_state = (state != S_IDLE) && (state != S_DONE);
    end

    // Search sequencer with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            key        <= '0;
            hi_q       <= '0;
            ram_addr   <= '0;
            keys_tried <= '0;
            core_start <= 1'b0;
            busy       <= 1'b0;
            found      <= 1'b0;
            not_found  <= 1'b0;
            lat_cnt    <= '0;
            byte_q     <= '0;
        end else begin
            core_start <= 1'b0;
            if (abort && in_busy_state) begin
                // Abort beats everything else in a busy state, including a
                // last-byte pass in CHECK; key and keys_tried are left as is.
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            key        <= key_lo;
                            hi_q       <= key_hi;
                            keys_tried <= '0;
                            found      <= 1'b0;
                            if (key_lo > key_hi) begin
                                not_found <= 1'b1;
                                state     <= S_DONE;
                            end else begin
                                not_found  <= 1'b0;
                                core_start <= 1'b1;
                                busy       <= 1'b1;
                                state      <= S_LAUNCH;
                            end
                        end
                    end
                    S_LAUNCH: begin
                        ram_addr <= '0;
                        state    <= S_WAIT_CORE;
                    end
                    S_WAIT_CORE: begin
                        if (core_done) begin
                            state <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        lat_cnt <= LAT_LOAD;
                        state   <= S_WAIT_RAM;
                    end
                    S_WAIT_RAM: begin
                        if (lat_cnt == LAT_TC) begin
                            byte_q <= ram_data;
                            state  <= S_CHECK;
                        end else begin
                            lat_cnt <= lat_cnt - LAT_W'(1);
                        end
                    end
                    S_CHECK: begin
                        if (!byte_ok) begin
                            state <= S_NEXT_KEY;
                        end else if (ram_addr == LAST_ADDR) begin
                            found <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            ram_addr <= ram_addr + ADDR_W'(1);
                            state    <= S_ISSUE;
                        end
                    end
                    S_NEXT_KEY: begin
                        keys_tried <= keys_tried + KEY_W'(1);
                        if (range_done) begin
                            not_found <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_DONE;
                        end else begin
                            key        <= key_next_x[KEY_W-1:0];
                            core_start <= 1'b1;
                            state      <= S_LAUNCH;
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rc4_key_search.sv
// Bench for rc4_key_search: two instances (step 1 / charset a-z / latency 1 and
// step 4 / printable / latency 3), each with a behavioural core + RAM model.
// Plaintext per key is a hash-derived pattern; a reference search over the key
// range predicts found/not_found/key/keys_tried/launch count.
module tb_rc4_key_search;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  start;
    logic [1:0]  abort;
    logic [1:0]  force_done;
    logic [1:0]  core_done_q;
    logic [1:0]  core_done_w;
    logic [1:0]  core_start;
    logic [1:0]  busy;
    logic [1:0]  found;
    logic [1:0]  not_found;
    logic [23:0] key_lo     [2];
    logic [23:0] key_hi     [2];
    logic [23:0] key        [2];
    logic [23:0] keys_tried [2];
    logic [4:0]  ram_addr   [2];
    logic [7:0]  ram_data   [2];

    // plaintext configuration, written only by the stimulus block
    bit          has_match [2];
    int unsigned match_key [2];
    bit          cap_last  [2];
    int unsigned salt      [2];

    // environment model state
    logic [7:0]  mem        [2][32];
    logic [4:0]  addr_hist  [2][4];
    int          core_cnt   [2];
    int unsigned cur_key    [2];
    int          n_launch   [2];
    int unsigned launch_log [2][8];

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign core_done_w = core_done_q | force_done;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rc4_key_search #(
            .KEY_W(24), .MSG_LEN(32), .ADDR_W(5),
            .RAM_LAT(g == 0 ? 1 : 3), .KEY_STEP(g == 0 ? 1 : 4), .CHARSET(g)
        ) u_dut (
            .clk(clk), .reset(reset), .start(start[g]), .abort(abort[g]),
            .key_lo(key_lo[g]), .key_hi(key_hi[g]),
            .core_start(core_start[g]), .core_done(core_done_w[g]),
            .ram_addr(ram_addr[g]), .ram_data(ram_data[g]),
            .key(key[g]), .busy(busy[g]), .found(found[g]),
            .not_found(not_found[g]), .keys_tried(keys_tried[g])
        );
    end

    function automatic int unsigned mix(input int unsigned a);
        int unsigned x;
        x = a ^ 32'h5bd1e995;
        x = x ^ (x << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        return x * 32'h9E3779B1;
    endfunction

    function automatic bit in_set(input int g, input logic [7:0] b);
        if (g == 0) return (b == 8'd32) || (b >= 8'd97 && b <= 8'd122);
        return (b >= 8'd32) && (b <= 8'd126);
    endfunction

    // Plaintext the core "decrypts" for key k: match key is all in-set,
    // every other key carries exactly one out-of-set byte at a hashed position.
    function automatic logic [7:0] pt_byte(input int g, input int unsigned k, input int unsigned i);
        int unsigned h;
        int unsigned bad_i;
        logic [7:0]  good;
        logic [7:0]  bad;
        h     = mix(k ^ salt[g] ^ (i * 32'h01000193));
        bad_i = mix(k ^ ~salt[g]) % 32;
        if (g == 0) good = (h % 27 == 26) ? 8'd32 : 8'(97 + h % 26);
        else        good = 8'(32 + h % 95);
        case (h % 4)
            0: bad = (g == 0) ? 8'd96  : 8'd31;
            1: bad = (g == 0) ? 8'd123 : 8'd127;
            2: bad = (g == 0) ? 8'd65  : 8'd10;
            default: bad = (g == 0) ? 8'd31 : 8'd200;
        endcase
        if (has_match[g] && k == match_key[g]) begin
            if (cap_last[g] && i == 31) return 8'd65;
            return (g == 0) ? 8'd97 : good;
        end
        if (i == bad_i) return bad;
        return good;
    endfunction

    // Decrypt core (10-cycle latency) and launch logger for both instances.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int g = 0; g < 2; g++) begin
                core_done_q[g] <= 1'b0;
                core_cnt[g]    <= 0;
                n_launch[g]    <= 0;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                addr_hist[g][0] <= ram_addr[g];
                for (int j = 1; j < 4; j++) addr_hist[g][j] <= addr_hist[g][j-1];
                core_done_q[g] <= 1'b0;
                if (core_start[g]) begin
                    core_cnt[g]                     <= 10;
                    cur_key[g]                      <= 32'(key[g]);
                    launch_log[g][n_launch[g] % 8]  <= 32'(key[g]);
                    n_launch[g]                     <= n_launch[g] + 1;
                end else if (core_cnt[g] != 0) begin
                    core_cnt[g] <= core_cnt[g] - 1;
                    if (core_cnt[g] == 1) begin
                        core_done_q[g] <= 1'b1;
                        for (int i = 0; i < 32; i++) mem[g][i] <= pt_byte(g, cur_key[g], i);
                    end
                end
            end
        end
    end

    // RAM read port: data for an address appears RAM_LAT cycles later.
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            ram_data[g] = mem[g][addr_hist[g][(g == 0) ? 0 : 2]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference search over the range, straight from the plaintext rules.
    task automatic ref_search(input int g, input longint lo, input longint hi,
                              output bit ef, output bit enf, output longint ek,
                              output longint et, output longint el);
        longint k;
        longint step;
        bit     pass;
        step = (g == 0) ? 1 : 4;
        ef = 0; enf = 0; et = 0; el = 0; ek = lo;
        if (lo > hi) begin
            enf = 1;
            return;
        end
        k = lo;
        forever begin
            el++;
            ek = k;
            pass = 1;
            for (int i = 0; i < 32; i++)
                if (!in_set(g, pt_byte(g, 32'(k), i))) pass = 0;
            if (pass) begin
                ef = 1;
                return;
            end
            et++;
            if (k + step > hi) begin
                enf = 1;
                return;
            end
            k = k + step;
        end
    endtask

    task automatic do_start(input int g, input longint lo, input longint hi, input bit with_abort);
        @(negedge clk);
        key_lo[g] = 24'(lo);
        key_hi[g] = 24'(hi);
        start[g]  = 1'b1;
        abort[g]  = with_abort;
        @(negedge clk);
        start[g]  = 1'b0;
        abort[g]  = 1'b0;
    endtask

    task automatic wait_idle(input int g, input string tag);
        int n;
        n = 0;
        while (busy[g] === 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 64'(busy[g]), 64'd0);
    endtask

    task automatic run_case(input int g, input string tag, input longint lo, input longint hi,
                            input bit poke, input bit with_abort);
        bit     ef, enf;
        longint ek, et, el;
        int     base;
        ref_search(g, lo, hi, ef, enf, ek, et, el);
        base = n_launch[g];
        do_start(g, lo, hi, with_abort);
        chk({tag, "_found0"}, 64'(found[g]), 64'd0);
        if (lo > hi) begin
            chk({tag, "_nf_now"}, 64'(not_found[g]), 64'd1);
            chk({tag, "_busy_now"}, 64'(busy[g]), 64'd0);
        end else begin
            chk({tag, "_nf0"}, 64'(not_found[g]), 64'd0);
            chk({tag, "_cs_now"}, 64'(core_start[g]), 64'd1);
        end
        if (poke) begin
            repeat (5) @(negedge clk);
            key_lo[g] = 24'h50;
            key_hi[g] = 24'h60;
            start[g]  = 1'b1;
            @(negedge clk);
            start[g]  = 1'b0;
        end
        wait_idle(g, tag);
        chk({tag, "_found"}, 64'(found[g]), 64'(ef));
        chk({tag, "_nf"}, 64'(not_found[g]), 64'(enf));
        chk({tag, "_key"}, 64'(key[g]), 64'(ek));
        chk({tag, "_tried"}, 64'(keys_tried[g]), 64'(et));
        chk({tag, "_launches"}, 64'(n_launch[g] - base), 64'(el));
    endtask

    initial begin
        int base;
        longint lo, span;
        reset = 1'b1;
        start = '0;
        abort = '0;
        force_done = '0;
        for (int g = 0; g < 2; g++) begin
            key_lo[g] = '0;
            key_hi[g] = '0;
            has_match[g] = 0;
            match_key[g] = 0;
            cap_last[g] = 0;
            salt[g] = $urandom;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int g = 0; g < 2; g++) begin
            chk("rst_key", 64'(key[g]), 64'd0);
            chk("rst_tried", 64'(keys_tried[g]), 64'd0);
            chk("rst_addr", 64'(ram_addr[g]), 64'd0);
            chk("rst_flags", 64'({core_start[g], busy[g], found[g], not_found[g]}), 64'd0);
        end

        // match at key 5 in a huge range
        has_match[0] = 1; match_key[0] = 5;
        run_case(0, "t1", 0, 24'h3FFFFF, 0, 0);

        // no match, and a start pulse while busy that must be ignored
        has_match[0] = 0;
        run_case(0, "t2", 24'h10, 24'h13, 1, 0);

        // interleaved step 4: keys 1,5,9
        has_match[1] = 1; match_key[1] = 9;
        base = n_launch[1];
        run_case(1, "t3a", 1, 10, 0, 0);
        chk("t3a_k0", 64'(launch_log[1][(base + 0) % 8]), 64'd1);
        chk("t3a_k1", 64'(launch_log[1][(base + 1) % 8]), 64'd5);
        chk("t3a_k2", 64'(launch_log[1][(base + 2) % 8]), 64'd9);
        run_case(1, "t3b", 1, 8, 0, 0);

        // capital letter in the last byte: rejected by a-z set, accepted by printable
        has_match[0] = 1; match_key[0] = 7; cap_last[0] = 1;
        has_match[1] = 1; match_key[1] = 7; cap_last[1] = 1;
        run_case(0, "t4a", 7, 7, 0, 0);
        run_case(1, "t4b", 7, 7, 0, 0);
        cap_last[0] = 0; cap_last[1] = 0;

        // abort three cycles into WAIT_CORE
        has_match[0] = 0;
        do_start(0, 3, 100, 0);
        chk("t5_cs", 64'(core_start[0]), 64'd1);
        repeat (3) @(negedge clk);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        chk("t5_busy", 64'(busy[0]), 64'd0);
        chk("t5_flags", 64'({found[0], not_found[0]}), 64'd0);
        chk("t5_key", 64'(key[0]), 64'd3);
        chk("t5_tried", 64'(keys_tried[0]), 64'd0);
        repeat (12) @(negedge clk);
        force_done[0] = 1'b1;
        @(negedge clk);
        force_done[0] = 1'b0;
        @(negedge clk);
        chk("t5_idle_busy", 64'(busy[0]), 64'd0);
        chk("t5_idle_cs", 64'(core_start[0]), 64'd0);
        has_match[0] = 1; match_key[0] = 21;
        run_case(0, "t5r", 20, 22, 0, 1);

        // top of key space, no wrap
        has_match[0] = 0; has_match[1] = 0;
        run_case(0, "t6a", 24'hFFFFFE, 24'hFFFFFF, 0, 0);
        run_case(1, "t6b", 24'hFFFFFA, 24'hFFFFFF, 0, 0);
        run_case(0, "t6c", 5, 4, 0, 0);

        // randomized ranges against the reference search
        for (int r = 0; r < 6; r++) begin
            salt[r % 2]      = $urandom;
            lo               = longint'($urandom_range(0, 24'hFFFF00));
            span             = longint'($urandom_range(0, 6));
            has_match[r % 2] = 1'($urandom_range(0, 1));
            match_key[r % 2] = 32'(lo) + $urandom_range(0, 32'(span) + 2);
            cap_last[r % 2]  = 1'($urandom_range(0, 1));
            run_case(r % 2, $sformatf("rnd%0d", r), lo, lo + span, 0, 0);
        end
        cap_last[0] = 0; cap_last[1] = 0;

        // reset in the middle of a long search
        has_match[0] = 0;
        do_start(0, 24'h100, 24'h1000, 0);
        repeat (200) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_key", 64'(key[0]), 64'd0);
        chk("rst_mid_tried", 64'(keys_tried[0]), 64'd0);
        chk("rst_mid_flags", 64'({core_start[0], busy[0], found[0], not_found[0]}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
